// File: rtl/lc3b_types.sv
// Shared LC-3b memory types: the 128-bit cache line (8 x lc3b_word), the
// byte-offset width within a line, and the request opcode.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [8*16-1:0] lc3b_line;

  localparam int unsigned LC3B_OFFSET_WIDTH = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } pmem_op_e;

endpackage

// File: rtl/pmem_responder_if.sv
// Physical-memory line bus between a cache (master) and the memory model (slave).
interface pmem_if;
  import lc3b_types::*;

  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  lc3b_line    pmem_wdata;
  logic        pmem_resp;
  lc3b_line    pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/pmem_line_array.sv
// Line storage: synchronous write, combinational read. Not reset, so contents
// survive rst and are undefined after power-up.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int unsigned IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  lc3b_line            wr_line,
  input  logic [IDX_BITS-1:0] rd_idx,
  output lc3b_line            rd_line
);

  lc3b_line lines [0:(1 << IDX_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en) lines[wr_idx] <= wr_line;
  end

  assign rd_line = lines[rd_idx];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder: accepts one line read/write, answers
// with a single pmem_resp pulse LATENCY cycles later, and flags protocol misuse.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned IDX_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  pmem_if.slave pmem,
  output logic busy,
  output logic proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] CD_LOAD = 4'(LATENCY - 1);

  state_e              state;
  logic [3:0]          countdown;
  logic [15:0]         hold_addr;
  lc3b_line            hold_wdata;
  pmem_op_e            hold_op;
  pmem_op_e            live_op;
  logic                req;
  logic                wr_en;
  logic                changed;
  logic [IDX_BITS-1:0] live_idx;
  logic [IDX_BITS-1:0] hold_idx;
  logic [IDX_BITS-1:0] rd_idx;
  lc3b_line            array_rdata;

  assign req      = pmem.pmem_read | pmem.pmem_write;
  assign live_op  = pmem.pmem_write ? OP_WRITE : OP_READ;
  assign live_idx = pmem.pmem_address[IDX_BITS+LC3B_OFFSET_WIDTH-1:LC3B_OFFSET_WIDTH];
  assign hold_idx = hold_addr[IDX_BITS+LC3B_OFFSET_WIDTH-1:LC3B_OFFSET_WIDTH];

  // A LATENCY=1 read samples the array on the accept edge, before hold regs load.
  assign rd_idx = (state == IDLE) ? live_idx : hold_idx;
  assign wr_en  = (state == RESP) && (hold_op == OP_WRITE);

  // wdata is only meaningful for writes, so reads may let it float.
  assign changed = !req
                || (pmem.pmem_address != hold_addr)
                || (live_op != hold_op)
                || ((hold_op == OP_WRITE) && (pmem.pmem_wdata != hold_wdata));

  pmem_line_array #(.IDX_BITS(IDX_BITS)) u_lines (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (hold_idx),
    .wr_line (hold_wdata),
    .rd_idx  (rd_idx),
    .rd_line (array_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      countdown       <= '0;
      hold_addr       <= '0;
      hold_wdata      <= '0;
      hold_op         <= OP_READ;
      pmem.pmem_resp  <= 1'b0;
      pmem.pmem_rdata <= '0;
      busy            <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            hold_addr  <= pmem.pmem_address;
            hold_wdata <= pmem.pmem_wdata;
            hold_op    <= live_op;
            busy       <= 1'b1;
            if (pmem.pmem_read && pmem.pmem_write) proto_err <= 1'b1;
            if (LATENCY == 1) begin
              state          <= RESP;
              countdown      <= '0;
              pmem.pmem_resp <= 1'b1;
              if (live_op == OP_READ) pmem.pmem_rdata <= array_rdata;
            end else begin
              state     <= WAIT;
              countdown <= CD_LOAD;
            end
          end
        end
        WAIT: begin
          if (countdown != 4'd0) countdown <= countdown - 4'd1;
          if (changed) proto_err <= 1'b1;
          // Entering RESP on the 1->0 step makes pmem_resp visible LATENCY cycles after accept.
          if (countdown <= 4'd1) begin
            state          <= RESP;
            pmem.pmem_resp <= 1'b1;
            if (hold_op == OP_READ) pmem.pmem_rdata <= array_rdata;
          end
        end
        RESP: begin
          pmem.pmem_resp <= 1'b0;
          state          <= RELEASE;
        end
        RELEASE: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          pmem.pmem_resp <= 1'b0;
        end
      endcase
    end
  end

endmodule
